mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Single-port memory arbiter for the DAPA2014 core. It shares one 8-bit-address, 16-bit-word memory port between the instruction-fetch unit and the LDS/STS data path. The memory itself is combinational-read and synchronous-write; the arbiter grants one access per cycle and returns registered read data one cycle later. It sits between the control unit and the memory, and it is the only block that drives the memory address and write strobes.

## Interface
- AW, 8, address width
- DW, 16, word width
- MAX_DATA_STREAK, 4, maximum consecutive data grants while fetch is waiting (fairness build only; range 1–15)

- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  AW  fetch address (PC)
- if_gnt  out  1  fetch granted this cycle (combinational)
- if_valid  out  1  if_rdata valid (registered, 1-cycle pulse)
- if_rdata  out  DW  fetched instruction word
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = STS write, 0 = LDS read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_gnt  out  1  data granted this cycle (combinational)
- d_valid  out  1  read data valid / write done (registered, 1-cycle pulse)
- d_rdata  out  DW  loaded word
- mem_addr  out  AW  memory address
- mem_we  out  1  memory write enable
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  combinational memory read data

## Operation
- The block keeps a per-cycle grant decision with these states:
  - IDLE: no request is pending.
  - GNT_IF: if_req is pending and wins.
  - GNT_D: d_req is pending and wins.
- Priority, default build: strict. d_req beats if_req, so the data path never stalls behind fetch.
- Exactly one of if_gnt/d_gnt is high in a given cycle, or neither is. gnt = req AND winner.
- When the data path is granted:
  - mem_addr = d_addr.
  - mem_we = d_we.
  - mem_wdata = d_wdata.
- When fetch is granted:
  - mem_addr = if_addr.
  - mem_we = 0.
- When idle:
  - mem_addr holds the last granted address.
  - mem_we = 0.
  - mem_wdata = 0.
- On the clock edge after a fetch grant:
  - if_rdata is loaded from mem_rdata.
  - if_valid goes to 1 for one cycle.
- On the clock edge after a data read grant:
  - d_rdata is loaded from mem_rdata.
  - d_valid goes to 1.
- On the clock edge after a data write grant:
  - d_valid goes to 1.
  - d_rdata is left unchanged.
- Requester protocol:
  - A requester keeps req, addr and wdata stable until it samples gnt = 1.
  - In the next cycle it may assert req again with a new address, so back-to-back grants to the same requester are legal.
- Read-after-write to the same address in consecutive cycles returns the new data, because the memory write commits at the edge that ends the write cycle.

## Timing
- Reset values:
  - if_valid = 0, d_valid = 0.
  - if_rdata = 0, d_rdata = 0.
  - mem_addr = 0, mem_we = 0, mem_wdata = 0.
  - Streak counter = 0.
- Grant latency is 0 cycles: gnt is in the same cycle as req when that requester wins.
- Data latency is 1 cycle: valid is in cycle N+1 for a grant in cycle N.
- Throughput is 1 access per cycle, in total.
- Both requests in the same cycle: one grant only. The loser keeps req and is served in a later cycle.
- reset_n asserted mid-access:
  - All registered outputs clear at once.
  - A pending valid is dropped.
  - gnt and mem_we are forced to 0 while reset_n = 0.
- If a requester drops req without a grant, the request is discarded and no valid is produced.

## Configuration
- MEM_ARB_FAIR_EN defined:
  - A 4-bit streak counter increments on every d_gnt taken while if_req = 1.
  - The counter clears on if_gnt, and when if_req = 0.
  - When the counter equals MAX_DATA_STREAK and both requests are pending, if_req wins and the counter clears.
  - Result: fetch waits at most MAX_DATA_STREAK cycles.
- MEM_ARB_FAIR_EN undefined:
  - Strict data priority and no counter logic.
  - Fetch can starve indefinitely under continuous d_req.

## Test plan
The memory model returns mem[a] = {8'hA5, a}.

- Reset release, no requests -> all outputs 0 and no gnt for 10 cycles.
- if_req = 1, if_addr = 8'h02 -> if_gnt in the same cycle; next cycle if_valid = 1, if_rdata = 16'hA502.
- d_req = 1, d_we = 1, d_addr = 8'h80, d_wdata = 16'h1234, then d_req read at 8'h80 in the next cycle -> mem_we high for 1 cycle, d_valid on both accesses, d_rdata = 16'h1234.
- if_req and d_req both asserted at cycle 0 (addresses 8'h00 and 8'h81) -> d_gnt at cycle 0, if_gnt at cycle 1, d_rdata = 16'hA581 at cycle 1, if_rdata = 16'hA500 at cycle 2.
- Continuous d_req plus if_req held for 12 cycles:
  - With MEM_ARB_FAIR_EN: exactly 4 d_gnt, then 1 if_gnt, repeating.
  - Without it: no if_gnt.
- reset_n pulled low the cycle after a d_gnt -> d_valid stays 0 and d_rdata reads 0 after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter, fetch vs LDS/STS data path
// Optional fetch-fairness streak limit enabled by defining MEM_ARB_FAIR_EN.
module mem_port_arbiter #(
    parameter int AW              = 8,
    parameter int DW              = 16,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_D  = 2'd2
    } grant_e;

    if (MAX_DATA_STREAK < 1 || MAX_DATA_STREAK > 15) begin : g_bad_streak
        $error("MAX_DATA_STREAK must be in 1..15");
    end

    grant_e          grant;
    logic            fair_force_if;
    logic [AW-1:0]   last_addr_q, last_addr_d;
    logic            if_valid_q, if_valid_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic            d_valid_q, d_valid_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;

`ifdef MEM_ARB_FAIR_EN
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    logic [3:0] streak_q, streak_d;

    // Once data has won STREAK_MAX times in a row over a waiting fetch, fetch goes next.
    assign fair_force_if = if_req && d_req && (streak_q == STREAK_MAX);

    always_comb begin
        streak_d = streak_q;
        if (if_gnt || !if_req) begin
            streak_d = '0;
        end else if (d_gnt) begin
            streak_d = streak_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign fair_force_if = 1'b0;
`endif

    // Grant is decided fresh every cycle; holding reset suppresses every grant.
    always_comb begin
        grant = IDLE;
        if (!reset_n) begin
            grant = IDLE;
        end else if (d_req && !fair_force_if) begin
            grant = GNT_D;
        end else if (if_req) begin
            grant = GNT_IF;
        end
    end

    assign if_gnt = (grant == GNT_IF);
    assign d_gnt  = (grant == GNT_D);

    always_comb begin
        mem_addr  = last_addr_q;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (grant)
            GNT_D: begin
                mem_addr  = d_addr;
                mem_we    = d_we;
                mem_wdata = d_wdata;
            end
            GNT_IF: begin
                mem_addr = if_addr;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        last_addr_d = last_addr_q;
        if_valid_d  = if_gnt;
        if_rdata_d  = if_rdata_q;
        d_valid_d   = d_gnt;
        d_rdata_d   = d_rdata_q;
        if (grant != IDLE) begin
            last_addr_d = mem_addr;
        end
        if (if_gnt) begin
            if_rdata_d = mem_rdata;
        end
        // A write completes with d_valid but leaves the last loaded word in place.
        if (d_gnt && !d_we) begin
            d_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_addr_q <= '0;
            if_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_valid_q   <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            last_addr_q <= last_addr_d;
            if_valid_q  <= if_valid_d;
            if_rdata_q  <= if_rdata_d;
            d_valid_q   <= d_valid_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_valid = if_valid_q;
    assign if_rdata = if_rdata_q;
    assign d_valid  = d_valid_q;
    assign d_rdata  = d_rdata_q;

endmodule
